// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: datapath widths, ALU operation codes and the
// EX-stage control bundle used by the ID/EX register.
package pipe_pkg;

    localparam int DW = 32;
    localparam int RW = 5;
    localparam int CW = 4;
    localparam int SW = 5;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_NOR  = 4'b0011;
    localparam logic [3:0] ALU_SLL  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_XOR  = 4'b1000;
    localparam logic [3:0] ALU_SRLV = 4'b1001;
    localparam logic [3:0] ALU_SRAV = 4'b1010;

    typedef struct packed {
        logic valid;
        logic reg_write;
        logic mem_read;
        logic mem_write;
        logic mem_to_reg;
    } ex_ctl_t;

    // An empty ID slot must not leave side effects in flight, so every control
    // bit is qualified by the valid flag at capture time.
    function automatic ex_ctl_t make_ctl(input logic valid, input logic reg_write,
                                         input logic mem_read, input logic mem_write,
                                         input logic mem_to_reg);
        ex_ctl_t c;
        c.valid      = valid;
        c.reg_write  = valid & reg_write;
        c.mem_read   = valid & mem_read;
        c.mem_write  = valid & mem_write;
        c.mem_to_reg = valid & mem_to_reg;
        return c;
    endfunction

endpackage

// File: rtl/id_ex_stage_fwd_mux.sv
// Operand forwarding select for one EX source register: EX/MEM result first,
// then MEM/WB result, otherwise the value read from the register file in ID.
import pipe_pkg::*;

module fwd_mux #(
    parameter int DW = pipe_pkg::DW,
    parameter int RW = pipe_pkg::RW
) (
    input  logic [RW-1:0] i_idx,
    input  logic [DW-1:0] i_regval,
    input  logic          i_exmem_reg_write,
    input  logic [RW-1:0] i_exmem_rd,
    input  logic [DW-1:0] i_exmem_result,
    input  logic          i_memwb_reg_write,
    input  logic [RW-1:0] i_memwb_rd,
    input  logic [DW-1:0] i_memwb_result,
    output logic [DW-1:0] o_value
);

    logic w_exmem_hit;
    logic w_memwb_hit;

    // $0 is hardwired, so a pending write to it must never shadow the read.
    assign w_exmem_hit = i_exmem_reg_write && (i_exmem_rd != '0) && (i_exmem_rd == i_idx);
    assign w_memwb_hit = i_memwb_reg_write && (i_memwb_rd != '0) && (i_memwb_rd == i_idx);

    always_comb begin
        o_value = i_regval;
        if (w_exmem_hit) begin
            o_value = i_exmem_result;
        end else if (w_memwb_hit) begin
            o_value = i_memwb_result;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX operand forwarding and load-use stall
// detection back to PC and IF/ID.
import pipe_pkg::*;

module id_ex_stage #(
    parameter int DW = pipe_pkg::DW,
    parameter int RW = pipe_pkg::RW,
    parameter int CW = pipe_pkg::CW
) (
    input  logic          i_clk,
    input  logic          i_reset_n,
    input  logic          i_flush,
    input  logic          i_id_valid,
    input  logic [RW-1:0] i_id_rs,
    input  logic [RW-1:0] i_id_rt,
    input  logic [RW-1:0] i_id_rd,
    input  logic [DW-1:0] i_id_rs_val,
    input  logic [DW-1:0] i_id_rt_val,
    input  logic [DW-1:0] i_id_imm,
    input  logic [4:0]    i_id_shamt,
    input  logic [CW-1:0] i_id_alu_ctl,
    input  logic          i_id_shift_c,
    input  logic          i_id_alu_src,
    input  logic          i_id_reg_dst,
    input  logic          i_id_reg_write,
    input  logic          i_id_mem_read,
    input  logic          i_id_mem_write,
    input  logic          i_id_mem_to_reg,
    input  logic          i_exmem_reg_write,
    input  logic [RW-1:0] i_exmem_rd,
    input  logic [DW-1:0] i_exmem_result,
    input  logic          i_memwb_reg_write,
    input  logic [RW-1:0] i_memwb_rd,
    input  logic [DW-1:0] i_memwb_result,
    output logic          o_stall,
    output logic [DW-1:0] o_alu_a,
    output logic [DW-1:0] o_alu_b,
    output logic [CW-1:0] o_alu_ctl,
    output logic          o_alu_shift_c,
    output logic [4:0]    o_alu_shift_v,
    output logic [DW-1:0] o_ex_store_data,
    output logic [RW-1:0] o_ex_dest,
    output logic          o_ex_valid,
    output logic          o_ex_reg_write,
    output logic          o_ex_mem_read,
    output logic          o_ex_mem_write,
    output logic          o_ex_mem_to_reg
);

    ex_ctl_t       r_ctl;
    logic [RW-1:0] r_dest;
    logic [RW-1:0] r_rs;
    logic [RW-1:0] r_rt;
    logic [DW-1:0] r_rs_val;
    logic [DW-1:0] r_rt_val;
    logic [DW-1:0] r_imm;
    logic [4:0]    r_shamt;
    logic [CW-1:0] r_alu_ctl;
    logic          r_shift_c;
    logic          r_alu_src;

    logic          w_stall;
    logic          w_dest_hit;
    logic [DW-1:0] w_fwd_rs;
    logic [DW-1:0] w_fwd_rt;

    // A load in EX cannot supply its data until MEM, so a dependent ID
    // instruction has to wait one cycle behind a bubble.
    assign w_dest_hit = (r_dest == i_id_rs) || (r_dest == i_id_rt);
    assign w_stall    = r_ctl.valid && r_ctl.mem_read && (r_dest != '0) &&
                        i_id_valid && w_dest_hit;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_ctl     <= '0;
            r_dest    <= '0;
            r_rs      <= '0;
            r_rt      <= '0;
            r_rs_val  <= '0;
            r_rt_val  <= '0;
            r_imm     <= '0;
            r_shamt   <= '0;
            r_alu_ctl <= '0;
            r_shift_c <= 1'b0;
            r_alu_src <= 1'b0;
        end else if (i_flush || w_stall) begin
            r_ctl     <= '0;
            r_dest    <= '0;
            r_rs      <= '0;
            r_rt      <= '0;
            r_rs_val  <= '0;
            r_rt_val  <= '0;
            r_imm     <= '0;
            r_shamt   <= '0;
            r_alu_ctl <= '0;
            r_shift_c <= 1'b0;
            r_alu_src <= 1'b0;
        end else begin
            r_ctl     <= make_ctl(i_id_valid, i_id_reg_write, i_id_mem_read,
                                  i_id_mem_write, i_id_mem_to_reg);
            r_dest    <= i_id_reg_dst ? i_id_rd : i_id_rt;
            r_rs      <= i_id_rs;
            r_rt      <= i_id_rt;
            r_rs_val  <= i_id_rs_val;
            r_rt_val  <= i_id_rt_val;
            r_imm     <= i_id_imm;
            r_shamt   <= i_id_shamt;
            r_alu_ctl <= i_id_alu_ctl;
            r_shift_c <= i_id_shift_c;
            r_alu_src <= i_id_alu_src;
        end
    end

    fwd_mux #(.DW(DW), .RW(RW)) u_fwd_rs (
        .i_idx             (r_rs),
        .i_regval          (r_rs_val),
        .i_exmem_reg_write (i_exmem_reg_write),
        .i_exmem_rd        (i_exmem_rd),
        .i_exmem_result    (i_exmem_result),
        .i_memwb_reg_write (i_memwb_reg_write),
        .i_memwb_rd        (i_memwb_rd),
        .i_memwb_result    (i_memwb_result),
        .o_value           (w_fwd_rs)
    );

    fwd_mux #(.DW(DW), .RW(RW)) u_fwd_rt (
        .i_idx             (r_rt),
        .i_regval          (r_rt_val),
        .i_exmem_reg_write (i_exmem_reg_write),
        .i_exmem_rd        (i_exmem_rd),
        .i_exmem_result    (i_exmem_result),
        .i_memwb_reg_write (i_memwb_reg_write),
        .i_memwb_rd        (i_memwb_rd),
        .i_memwb_result    (i_memwb_result),
        .o_value           (w_fwd_rt)
    );

    // Shifts keep alu_src low, so operand B naturally carries the forwarded rt.
    assign o_alu_a         = w_fwd_rs;
    assign o_alu_b         = r_alu_src ? r_imm : w_fwd_rt;
    assign o_ex_store_data = w_fwd_rt;

    assign o_stall         = w_stall;
    assign o_alu_ctl       = r_alu_ctl;
    assign o_alu_shift_c   = r_shift_c;
    assign o_alu_shift_v   = r_shamt;
    assign o_ex_dest       = r_dest;
    assign o_ex_valid      = r_ctl.valid;
    assign o_ex_reg_write  = r_ctl.reg_write;
    assign o_ex_mem_read   = r_ctl.mem_read;
    assign o_ex_mem_write  = r_ctl.mem_write;
    assign o_ex_mem_to_reg = r_ctl.mem_to_reg;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed hazard/forwarding scenarios
// followed by random traffic compared against an instruction-level model.
module tb_id_ex_stage;

    logic        i_clk = 1'b0;
    logic        i_reset_n;
    logic        i_flush;
    logic        i_id_valid;
    logic [4:0]  i_id_rs, i_id_rt, i_id_rd;
    logic [31:0] i_id_rs_val, i_id_rt_val, i_id_imm;
    logic [4:0]  i_id_shamt;
    logic [3:0]  i_id_alu_ctl;
    logic        i_id_shift_c, i_id_alu_src, i_id_reg_dst;
    logic        i_id_reg_write, i_id_mem_read, i_id_mem_write, i_id_mem_to_reg;
    logic        i_exmem_reg_write;
    logic [4:0]  i_exmem_rd;
    logic [31:0] i_exmem_result;
    logic        i_memwb_reg_write;
    logic [4:0]  i_memwb_rd;
    logic [31:0] i_memwb_result;
    logic        o_stall;
    logic [31:0] o_alu_a, o_alu_b, o_ex_store_data;
    logic [3:0]  o_alu_ctl;
    logic        o_alu_shift_c;
    logic [4:0]  o_alu_shift_v;
    logic [4:0]  o_ex_dest;
    logic        o_ex_valid, o_ex_reg_write, o_ex_mem_read, o_ex_mem_write, o_ex_mem_to_reg;

    id_ex_stage dut (
        .i_clk(i_clk), .i_reset_n(i_reset_n), .i_flush(i_flush), .i_id_valid(i_id_valid),
        .i_id_rs(i_id_rs), .i_id_rt(i_id_rt), .i_id_rd(i_id_rd),
        .i_id_rs_val(i_id_rs_val), .i_id_rt_val(i_id_rt_val), .i_id_imm(i_id_imm),
        .i_id_shamt(i_id_shamt), .i_id_alu_ctl(i_id_alu_ctl), .i_id_shift_c(i_id_shift_c),
        .i_id_alu_src(i_id_alu_src), .i_id_reg_dst(i_id_reg_dst),
        .i_id_reg_write(i_id_reg_write), .i_id_mem_read(i_id_mem_read),
        .i_id_mem_write(i_id_mem_write), .i_id_mem_to_reg(i_id_mem_to_reg),
        .i_exmem_reg_write(i_exmem_reg_write), .i_exmem_rd(i_exmem_rd),
        .i_exmem_result(i_exmem_result), .i_memwb_reg_write(i_memwb_reg_write),
        .i_memwb_rd(i_memwb_rd), .i_memwb_result(i_memwb_result),
        .o_stall(o_stall), .o_alu_a(o_alu_a), .o_alu_b(o_alu_b), .o_alu_ctl(o_alu_ctl),
        .o_alu_shift_c(o_alu_shift_c), .o_alu_shift_v(o_alu_shift_v),
        .o_ex_store_data(o_ex_store_data), .o_ex_dest(o_ex_dest), .o_ex_valid(o_ex_valid),
        .o_ex_reg_write(o_ex_reg_write), .o_ex_mem_read(o_ex_mem_read),
        .o_ex_mem_write(o_ex_mem_write), .o_ex_mem_to_reg(o_ex_mem_to_reg)
    );

    always #5 i_clk = ~i_clk;

    // Instruction currently sitting in EX, as the model sees it.
    typedef struct packed {
        bit        valid, rw, mr, mw, m2r;
        bit [4:0]  dest, rs, rt, shamt;
        bit [31:0] rs_val, rt_val, imm;
        bit [3:0]  ctl;
        bit        shift_c, alu_src;
    } ex_instr_t;

    ex_instr_t m;
    bit        m_known;
    int        n_checks = 0;
    int        n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit [31:0] fwd(input bit [4:0] idx, input bit [31:0] regval);
        if (i_exmem_reg_write && i_exmem_rd != 0 && i_exmem_rd == idx) return i_exmem_result;
        if (i_memwb_reg_write && i_memwb_rd != 0 && i_memwb_rd == idx) return i_memwb_result;
        return regval;
    endfunction

    function automatic bit exp_stall();
        return m.valid && m.mr && m.dest != 0 && i_id_valid &&
               (m.dest == i_id_rs || m.dest == i_id_rt);
    endfunction

    task automatic check_all();
        check("stall", o_stall, exp_stall());
        check("ex_valid", o_ex_valid, m.valid);
        check("ex_reg_write", o_ex_reg_write, m.rw);
        check("ex_mem_read", o_ex_mem_read, m.mr);
        check("ex_mem_write", o_ex_mem_write, m.mw);
        check("ex_mem_to_reg", o_ex_mem_to_reg, m.m2r);
        if (m_known) begin
            check("alu_a", o_alu_a, fwd(m.rs, m.rs_val));
            check("alu_b", o_alu_b, m.alu_src ? m.imm : fwd(m.rt, m.rt_val));
            check("store_data", o_ex_store_data, fwd(m.rt, m.rt_val));
            check("alu_ctl", o_alu_ctl, m.ctl);
            check("shift_c", o_alu_shift_c, m.shift_c);
            check("shift_v", o_alu_shift_v, m.shamt);
            check("ex_dest", o_ex_dest, m.dest);
        end
    endtask

    // Check the current cycle at negedge+1, then advance the model across the edge.
    task automatic cycle();
        ex_instr_t nxt;
        bit        nk;
        #1;
        check_all();
        nxt = '0;
        nk  = 1'b1;
        if (!(i_flush || exp_stall())) begin
            nxt.valid   = i_id_valid;
            nxt.rw      = i_id_valid & i_id_reg_write;
            nxt.mr      = i_id_valid & i_id_mem_read;
            nxt.mw      = i_id_valid & i_id_mem_write;
            nxt.m2r     = i_id_valid & i_id_mem_to_reg;
            nxt.dest    = i_id_reg_dst ? i_id_rd : i_id_rt;
            nxt.rs      = i_id_rs;
            nxt.rt      = i_id_rt;
            nxt.rs_val  = i_id_rs_val;
            nxt.rt_val  = i_id_rt_val;
            nxt.imm     = i_id_imm;
            nxt.shamt   = i_id_shamt;
            nxt.ctl     = i_id_alu_ctl;
            nxt.shift_c = i_id_shift_c;
            nxt.alu_src = i_id_alu_src;
            nk          = i_id_valid;
        end
        @(posedge i_clk);
        m       = nxt;
        m_known = nk;
        @(negedge i_clk);
    endtask

    task automatic set_id(input bit v, input bit [4:0] rs, input bit [4:0] rt, input bit [4:0] rd,
                          input bit [31:0] rsv, input bit [31:0] rtv, input bit [31:0] imm,
                          input bit [4:0] sh, input bit [3:0] ctl, input bit sc, input bit asrc,
                          input bit rdst, input bit rw, input bit mr, input bit mw, input bit m2r);
        i_id_valid = v;   i_id_rs = rs;  i_id_rt = rt;  i_id_rd = rd;
        i_id_rs_val = rsv; i_id_rt_val = rtv; i_id_imm = imm; i_id_shamt = sh;
        i_id_alu_ctl = ctl; i_id_shift_c = sc; i_id_alu_src = asrc; i_id_reg_dst = rdst;
        i_id_reg_write = rw; i_id_mem_read = mr; i_id_mem_write = mw; i_id_mem_to_reg = m2r;
    endtask

    task automatic set_fwd(input bit ew, input bit [4:0] erd, input bit [31:0] eres,
                           input bit ww, input bit [4:0] wrd, input bit [31:0] wres);
        i_exmem_reg_write = ew; i_exmem_rd = erd; i_exmem_result = eres;
        i_memwb_reg_write = ww; i_memwb_rd = wrd; i_memwb_result = wres;
    endtask

    initial begin
        i_reset_n = 1'b0;
        i_flush   = 1'b0;
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        set_fwd(0, 0, 0, 0, 0, 0);
        m = '0;
        m_known = 1'b1;
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        check_all();
        i_reset_n = 1'b1;

        // EX/MEM forward into rs
        set_id(1, 3, 1, 2, 32'h1234, 32'h7, 0, 0, pipe_pkg::ALU_ADD, 0, 0, 1, 1, 0, 0, 0);
        cycle();
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        set_fwd(1, 3, 32'h10, 0, 0, 0);
        #1 check("exmem_fwd_rs", o_alu_a, 32'h10);
        cycle();

        // Both stages target $5: EX/MEM wins
        set_fwd(0, 0, 0, 0, 0, 0);
        set_id(1, 2, 5, 6, 32'h1, 32'h2, 0, 0, pipe_pkg::ALU_SUB, 0, 0, 1, 1, 0, 0, 0);
        cycle();
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        set_fwd(1, 5, 32'hAA, 1, 5, 32'hBB);
        #1 check("double_hazard_b", o_alu_b, 32'hAA);
        check("double_hazard_st", o_ex_store_data, 32'hAA);
        cycle();

        // $0 is never forwarded
        set_fwd(0, 0, 0, 0, 0, 0);
        set_id(1, 0, 1, 7, 0, 32'h3, 0, 0, pipe_pkg::ALU_OR, 0, 0, 1, 1, 0, 0, 0);
        cycle();
        set_fwd(1, 0, 32'hFFFF, 1, 0, 32'hEEEE);
        #1 check("zero_guard", o_alu_a, 32'h0);
        cycle();

        // Load-use: lw $4 in EX, dependent add in ID
        set_fwd(0, 0, 0, 0, 0, 0);
        set_id(1, 1, 4, 0, 32'h100, 0, 32'h8, 0, pipe_pkg::ALU_ADD, 0, 1, 0, 1, 1, 0, 1);
        cycle();
        set_id(1, 2, 4, 9, 32'h5, 32'h6, 0, 0, pipe_pkg::ALU_ADD, 0, 0, 1, 1, 0, 0, 0);
        #1 check("load_use_stall", o_stall, 1'b1);
        cycle();
        check("load_use_bubble", o_ex_valid, 1'b0);
        check("load_use_release", o_stall, 1'b0);
        cycle();
        check("load_use_capture", o_ex_valid, 1'b1);
        check("load_use_dest", o_ex_dest, 5'd9);

        // Flush together with stall, then SLL by shamt
        set_id(1, 1, 6, 0, 0, 0, 32'h4, 0, pipe_pkg::ALU_ADD, 0, 1, 0, 1, 1, 0, 1);
        cycle();
        set_id(1, 0, 6, 8, 0, 32'h3, 0, 7, pipe_pkg::ALU_SLL, 1, 0, 1, 1, 0, 0, 0);
        i_flush = 1'b1;
        #1 check("flush_stall_raised", o_stall, 1'b1);
        cycle();
        i_flush = 1'b0;
        check("flush_bubble", o_ex_valid, 1'b0);
        cycle();
        set_fwd(0, 0, 0, 1, 6, 32'h55);
        #1 check("sll_shift_v", o_alu_shift_v, 5'd7);
        check("sll_shift_c", o_alu_shift_c, 1'b1);
        check("sll_alu_b", o_alu_b, 32'h55);
        cycle();

        // Reset asserted while a load-use stall is active
        set_fwd(0, 0, 0, 0, 0, 0);
        set_id(1, 1, 4, 0, 32'h100, 0, 32'h8, 0, pipe_pkg::ALU_ADD, 0, 1, 0, 1, 1, 0, 1);
        cycle();
        set_id(1, 4, 2, 9, 32'h5, 32'h6, 0, 0, pipe_pkg::ALU_ADD, 0, 0, 1, 1, 0, 0, 0);
        #1 check("pre_reset_stall", o_stall, 1'b1);
        #1 i_reset_n = 1'b0;
        #1;
        check("reset_stall", o_stall, 1'b0);
        check("reset_valid", o_ex_valid, 1'b0);
        check("reset_mem_read", o_ex_mem_read, 1'b0);
        check("reset_dest", o_ex_dest, 5'd0);
        check("reset_alu_a", o_alu_a, 32'd0);
        check("reset_alu_b", o_alu_b, 32'd0);
        check("reset_alu_ctl", o_alu_ctl, 4'd0);
        @(posedge i_clk);
        #1 check("reset_hold", o_ex_valid, 1'b0);
        m = '0;
        m_known = 1'b1;
        @(negedge i_clk);
        i_reset_n = 1'b1;

        for (int i = 0; i < 400; i++) begin
            i_flush = ($urandom_range(0, 9) == 0);
            set_id(($urandom_range(0, 4) != 0), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                   5'($urandom_range(0, 7)), $urandom, $urandom, $urandom, 5'($urandom),
                   4'($urandom_range(0, 10)), 1'($urandom), 1'($urandom), 1'($urandom),
                   1'($urandom), ($urandom_range(0, 2) == 0), 1'($urandom), 1'($urandom));
            set_fwd(1'($urandom), 5'($urandom_range(0, 7)), $urandom,
                    1'($urandom), 5'($urandom_range(0, 7)), $urandom);
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
